// File: rtl/div_mod_32bit.sv
`default_nettype none
// ============================================================================
// Module      : div_mod_32bit
// Description : Iterative restoring divider for the eBPF CPU ALU. It accepts
//               one operand pair through a valid/ready handshake and returns
//               quotient and remainder together after a fixed latency. One
//               quotient bit is resolved per cycle, MSB first.
//               Divide by zero gives quotient 0, remainder = dividend and
//               raises div_by_zero, so the CPU needs no trap logic.
//
//               Optional feature macro: DIVMOD_SIGNED_EN
//                 defined   -> is_signed selects two's-complement operation.
//                              A FIX cycle applies sign correction, which
//                              adds one cycle of latency to every
//                              nonzero-divisor operation.
//                 undefined -> all operations are unsigned and is_signed is
//                              ignored.
//
// Ports       : clk          clock, rising edge
//               rst          synchronous active-high reset
//               in_valid     operand pair valid
//               in_ready     block idle, operands accepted
//               dividend     numerator   [WIDTH-1:0]
//               divisor      denominator [WIDTH-1:0]
//               is_signed    two's-complement operation (signed build only)
//               out_valid    results valid, held until accepted
//               out_ready    consumer accepts results
//               quotient     dividend / divisor [WIDTH-1:0]
//               remainder    dividend % divisor [WIDTH-1:0]
//               div_by_zero  divisor was zero (valid with out_valid)
//
// Revision    : 1.0 - initial release
// ============================================================================
module div_mod_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int c_CW = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
`ifdef DIVMOD_SIGNED_EN
    localparam logic [1:0] c_ST_FIX  = 2'd2;
`endif
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [c_CW-1:0]  r_count;
    // r_quo starts as the dividend magnitude; dividend bits shift out of the
    // top while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;

    logic             w_div_zero;
    logic             w_run_last;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

`ifdef DIVMOD_SIGNED_EN
    logic             w_neg_a;
    logic             w_neg_b;
    logic             r_neg_q;
    logic             r_neg_r;

    assign w_neg_a = is_signed & dividend[WIDTH-1];
    assign w_neg_b = is_signed & divisor[WIDTH-1];
    // The magnitude of INT_MIN is itself, which reads correctly as unsigned.
    assign w_mag_a = w_neg_a ? (~dividend + 1'b1) : dividend;
    assign w_mag_b = w_neg_b ? (~divisor + 1'b1) : divisor;
`else
    logic             w_unused_is_signed;

    assign w_unused_is_signed = is_signed;
    assign w_mag_a            = dividend;
    assign w_mag_b            = divisor;
`endif

    assign in_ready   = (r_state == c_ST_IDLE);
    assign out_valid  = (r_state == c_ST_DONE);
    assign w_div_zero = (divisor == '0);
    assign w_run_last = (r_state == c_ST_RUN) && (r_count == c_LAST);

    // One restoring step: the partial remainder is WIDTH+1 bits wide, and its
    // top bit after the trial subtraction acts as the borrow/sign.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_div};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_qbit};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (in_valid) begin
                    w_next_state = w_div_zero ? c_ST_DONE : c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_run_last) begin
`ifdef DIVMOD_SIGNED_EN
                    w_next_state = c_ST_FIX;
`else
                    w_next_state = c_ST_DONE;
`endif
                end
            end
`ifdef DIVMOD_SIGNED_EN
            c_ST_FIX: begin
                w_next_state = c_ST_DONE;
            end
`endif
            c_ST_DONE: begin
                if (out_ready) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers. Results are written only on the edge
    // that enters DONE, so they stay stable while out_valid is high.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIVMOD_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_count <= '0;
                        r_quo   <= w_mag_a;
                        r_rem   <= '0;
                        r_div   <= w_mag_b;
`ifdef DIVMOD_SIGNED_EN
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
`endif
                        if (w_div_zero) begin
                            quotient    <= '0;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                c_ST_RUN: begin
                    r_count <= r_count + 1'b1;
                    r_quo   <= w_quo_next;
                    r_rem   <= w_rem_next;
`ifndef DIVMOD_SIGNED_EN
                    if (w_run_last) begin
                        quotient    <= w_quo_next;
                        remainder   <= w_rem_next;
                        div_by_zero <= 1'b0;
                    end
`endif
                end
`ifdef DIVMOD_SIGNED_EN
                c_ST_FIX: begin
                    quotient    <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
                    remainder   <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
                    div_by_zero <= 1'b0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_mod_32bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_mod_32bit
// Description : Self-checking bench for div_mod_32bit. Expected results are
//               pushed to a scoreboard queue when operands are driven and
//               popped when the divider presents its output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_mod_32bit;

    localparam int W = 32;
`ifdef DIVMOD_SIGNED_EN
    localparam int c_LAT       = W + 2;
    localparam bit c_SIGNED_EN = 1'b1;
`else
    localparam int c_LAT       = W + 1;
    localparam bit c_SIGNED_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    div_mod_32bit #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .is_signed   (is_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: eBPF semantics, C-style truncating signed division.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint sb_l;
        e.z = 1'b0;
        if (b == '0) begin
            e.q = '0;
            e.r = a;
            e.z = 1'b1;
        end else if (c_SIGNED_EN && s) begin
            sa   = longint'($signed(a));
            sb_l = longint'($signed(b));
            e.q  = W'(sa / sb_l);
            e.r  = W'(sa % sb_l);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Drives one operand pair; returns just after the transfer edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, output bit ok);
        int n = 0;
        ok = 1'b0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_val("send_timeout", in_ready, 1);
            return;
        end
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        sb.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        ok = 1'b1;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            check_val({tag, "_timeout"}, out_valid, 1);
            return;
        end
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_in_ready_busy"}, in_ready, 0);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 64'(sb.size()), 1);
            return;
        end
        e = sb.pop_front();
        check_val({tag, "_quotient"}, quotient, e.q);
        check_val({tag, "_remainder"}, remainder, e.r);
        check_val({tag, "_dbz"}, div_by_zero, e.z);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bit ok;
        send(a, b, s, ok);
        if (!ok) return;
        wait_out(tag, (b == '0) ? 1 : c_LAT);
        pop_compare(tag);
        @(posedge clk);
        #1;
        check_val({tag, "_post_out_valid"}, out_valid, 0);
        check_val({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    initial begin
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_in_ready", in_ready, 1);
        check_val("reset_out_valid", out_valid, 0);
        check_val("reset_quotient", quotient, 0);
        check_val("reset_remainder", remainder, 0);
        check_val("reset_dbz", div_by_zero, 0);
        rst = 1'b0;

        do_op("u100_7",     32'd100,        32'd7,          1'b0);
        do_op("umax_1",     32'hFFFF_FFFF,  32'd1,          1'b0);
        do_op("u5_max",     32'd5,          32'hFFFF_FFFF,  1'b0);
        do_op("u1234_0",    32'd1234,       32'd0,          1'b0);
        do_op("s1234_0",    32'd1234,       32'd0,          1'b1);
        do_op("sm7_2",      32'hFFFF_FFF9,  32'd2,          1'b1);
        do_op("s7_m2",      32'd7,          32'hFFFF_FFFE,  1'b1);
        do_op("smin_m1",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1);
        do_op("sm100_m7",   32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1);
        do_op("umin_3",     32'h8000_0000,  32'd3,          1'b0);
        do_op("eq",         32'd77,         32'd77,         1'b0);
        do_op("small_big",  32'd3,          32'd4,          1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            do_op("rand", a, b, 1'($urandom_range(0, 1)));
        end

        // Back-pressure: results must hold and new operands be ignored.
        out_ready = 1'b0;
        send(32'd100, 32'd7, 1'b0, ok);
        if (ok) begin
            wait_out("bp", c_LAT);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                in_valid = 1'b1;
                dividend = 32'(i + 50);
                divisor  = 32'd1;
                @(posedge clk);
                #1;
                check_val("bp_hold_valid", out_valid, 1);
                check_val("bp_hold_in_ready", in_ready, 0);
                check_val("bp_hold_quotient", quotient, sb[0].q);
                check_val("bp_hold_remainder", remainder, sb[0].r);
            end
            @(negedge clk);
            in_valid = 1'b0;
            pop_compare("bp");
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check_val("bp_release_in_ready", in_ready, 1);
            check_val("bp_release_out_valid", out_valid, 0);
            @(negedge clk);
            out_ready = 1'b0;
            repeat (c_LAT + 3) @(posedge clk);
            #1;
            check_val("bp_no_ghost_op", out_valid, 0);
            out_ready = 1'b1;
        end

        // Abort mid-RUN with reset; the partial result must vanish.
        send(32'd1000, 32'd3, 1'b0, ok);
        if (ok) begin
            repeat (9) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check_val("abort_out_valid", out_valid, 0);
            check_val("abort_in_ready", in_ready, 1);
            rst = 1'b0;
            void'(sb.pop_back());
        end
        do_op("after_abort", 32'd9, 32'd3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
